id_exe_reg: RTL
===============

ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: flush  in  1  branch-taken squash; freeze  in  1  hold (memory stall); cnt_clr  in  1  synchronous bubble-counter clear.
REQ-004 SHALL have: valid_in  in  1; cntrl_in  in  9  {EXE_CMD[3:0], MEM_W_EN, MEM_R_EN, WB_EN, B, S} from ID control decode.
REQ-005 SHALL have: pc_in  in  32; val_rn_in  in  32; val_rm_in  in  32; imm_in  in  1; shift_operand_in  in  12; signed_imm_24_in  in  24.
REQ-006 SHALL have: dest_in  in  4; src1_in  in  4; src2_in  in  4; sr_in  in  4  status flags {N,Z,C,V}.
REQ-007 SHALL have outputs: exe_cmd  out  4; mem_w_en, mem_r_en, wb_en, b, s  out  1 each.
REQ-008 SHALL have outputs: pc, val_rn, val_rm  out  32 each; imm  out  1; shift_operand  out  12; signed_imm_24  out  24.
REQ-009 SHALL have outputs: dest, src1, src2, sr  out  4 each; valid_out  out  1; bubble_cnt  out  16.
REQ-010 SHALL drive every output directly from a flop (no combinational input-to-output path).

Function
REQ-011 SHALL evaluate per-edge priority: rst low > flush > freeze > load.
REQ-012 Load (flush=0, freeze=0): all data fields SHALL capture their *_in values; valid_out SHALL take valid_in; latency exactly 1 cycle.
REQ-013 Load with valid_in=0: control outputs (exe_cmd, mem_w_en, mem_r_en, wb_en, b, s) SHALL be forced 0 regardless of cntrl_in; data fields still captured.
REQ-014 Load with valid_in=1: control outputs SHALL equal the corresponding cntrl_in bits unmodified.
REQ-015 Flush=1: all outputs except bubble_cnt SHALL become 0 on the next edge, independent of freeze.
REQ-016 Freeze=1, flush=0: all outputs except bubble_cnt SHALL hold their values.
REQ-017 Load with cntrl_in MEM_W_EN=1 and MEM_R_EN=1 (illegal) and valid_in=1: SHALL register a bubble (as REQ-013, valid_out=0).
REQ-018 bubble_cnt SHALL increment by 1 on each edge where a bubble is inserted: flush=1, or a load with valid_in=0, or a REQ-017 load.
REQ-019 bubble_cnt SHALL not change on freeze cycles without flush.
REQ-020 bubble_cnt SHALL saturate at 16'hFFFF (no wrap).
REQ-021 cnt_clr=1 SHALL set bubble_cnt to 0 on the next edge, overriding increment in the same cycle; cnt_clr SHALL not affect other outputs.
REQ-022 Simultaneous flush and freeze SHALL count one bubble and clear the stage.

Reset
REQ-023 rst low SHALL immediately (asynchronously) clear all outputs, including bubble_cnt and valid_out, to 0.
REQ-024 Outputs SHALL remain 0 while rst is low; first load SHALL occur on the first rising edge with rst high.
REQ-025 Reset asserted mid-freeze or mid-flush SHALL discard held state; no state survives reset.

Verification
REQ-026 Reset: rst low mid-cycle with valid_out=1, bubble_cnt=5 -> all outputs 0 before next edge.
REQ-027 Load: valid_in=1, cntrl_in=9'b0010_0_0_1_0_1, pc_in=32'h0000_0010, dest_in=4'h3 -> next edge exe_cmd=4'b0010, wb_en=1, s=1, pc=32'h10, dest=3, valid_out=1, bubble_cnt unchanged.
REQ-028 Freeze then flush: load as REQ-027, freeze=1 for 3 cycles -> outputs held; then flush=1 with freeze=1 -> all outputs 0, bubble_cnt +1.
REQ-029 Bubble sanitize: valid_in=0, cntrl_in=9'b0001_1_0_1_1_0 -> control outputs 0, valid_out=0, data fields captured, bubble_cnt +1; illegal MEM_W_EN=MEM_R_EN=1 with valid_in=1 -> same response.
REQ-030 Saturation/clear: drive flush for 65540 cycles -> bubble_cnt stays 16'hFFFF; cnt_clr=1 with flush=1 -> bubble_cnt=0 next edge.

Source files
------------

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register.
// Captures decoded control and operand fields from the decode stage and
// presents them, fully registered, to the execute stage. Supports squash
// (flush), hold (freeze), sanitising of invalid/illegal control words into
// bubbles, and a saturating bubble counter with synchronous clear.
module id_exe_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze,
    input  logic        cnt_clr,
    input  logic        valid_in,
    input  logic [8:0]  cntrl_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    input  logic [3:0]  sr_in,
    output logic [3:0]  exe_cmd,
    output logic        mem_w_en,
    output logic        mem_r_en,
    output logic        wb_en,
    output logic        b,
    output logic        s,
    output logic [31:0] pc,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic        imm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic [3:0]  dest,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic [3:0]  sr,
    output logic        valid_out,
    output logic [15:0] bubble_cnt
);

    // Control word layout: {EXE_CMD[3:0], MEM_W_EN, MEM_R_EN, WB_EN, B, S}.
    // A simultaneous memory write and read request is not a legal command.
    function automatic logic is_illegal_ctrl(input logic [8:0] ctrl);
        return ctrl[4] & ctrl[3];
    endfunction

    logic [8:0]  ctrl_r,   ctrl_nxt_s;
    logic        valid_r,  valid_nxt_s;
    logic [31:0] pc_r,     pc_nxt_s;
    logic [31:0] val_rn_r, val_rn_nxt_s;
    logic [31:0] val_rm_r, val_rm_nxt_s;
    logic        imm_r,    imm_nxt_s;
    logic [11:0] shift_r,  shift_nxt_s;
    logic [23:0] simm_r,   simm_nxt_s;
    logic [3:0]  dest_r,   dest_nxt_s;
    logic [3:0]  src1_r,   src1_nxt_s;
    logic [3:0]  src2_r,   src2_nxt_s;
    logic [3:0]  sr_r,     sr_nxt_s;
    logic [15:0] cnt_r,    cnt_nxt_s;

    logic load_bubble_s;
    logic bubble_evt_s;

    // A load becomes a bubble when the incoming slot is invalid or its control word is illegal.
    assign load_bubble_s = ~valid_in | is_illegal_ctrl(cntrl_in);
    // A bubble is inserted on every flush and on every non-frozen bubble load.
    assign bubble_evt_s  = flush | (~freeze & load_bubble_s);

    // Next-state selection for the stage contents: flush > freeze > load.
    always_comb begin
        ctrl_nxt_s   = ctrl_r;
        valid_nxt_s  = valid_r;
        pc_nxt_s     = pc_r;
        val_rn_nxt_s = val_rn_r;
        val_rm_nxt_s = val_rm_r;
        imm_nxt_s    = imm_r;
        shift_nxt_s  = shift_r;
        simm_nxt_s   = simm_r;
        dest_nxt_s   = dest_r;
        src1_nxt_s   = src1_r;
        src2_nxt_s   = src2_r;
        sr_nxt_s     = sr_r;
        if (flush) begin
            ctrl_nxt_s   = 9'd0;
            valid_nxt_s  = 1'b0;
            pc_nxt_s     = 32'd0;
            val_rn_nxt_s = 32'd0;
            val_rm_nxt_s = 32'd0;
            imm_nxt_s    = 1'b0;
            shift_nxt_s  = 12'd0;
            simm_nxt_s   = 24'd0;
            dest_nxt_s   = 4'd0;
            src1_nxt_s   = 4'd0;
            src2_nxt_s   = 4'd0;
            sr_nxt_s     = 4'd0;
        end else if (freeze) begin
            ctrl_nxt_s   = ctrl_r;
            valid_nxt_s  = valid_r;
        end else begin
            pc_nxt_s     = pc_in;
            val_rn_nxt_s = val_rn_in;
            val_rm_nxt_s = val_rm_in;
            imm_nxt_s    = imm_in;
            shift_nxt_s  = shift_operand_in;
            simm_nxt_s   = signed_imm_24_in;
            dest_nxt_s   = dest_in;
            src1_nxt_s   = src1_in;
            src2_nxt_s   = src2_in;
            sr_nxt_s     = sr_in;
            if (load_bubble_s) begin
                ctrl_nxt_s  = 9'd0;
                valid_nxt_s = 1'b0;
            end else begin
                ctrl_nxt_s  = cntrl_in;
                valid_nxt_s = 1'b1;
            end
        end
    end

    // Bubble counter next value: clear wins, otherwise saturating increment.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_clr) begin
            cnt_nxt_s = 16'd0;
        end else if (bubble_evt_s && (cnt_r != 16'hFFFF)) begin
            cnt_nxt_s = cnt_r + 16'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Stage and counter flops; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_r   <= 9'd0;
            valid_r  <= 1'b0;
            pc_r     <= 32'd0;
            val_rn_r <= 32'd0;
            val_rm_r <= 32'd0;
            imm_r    <= 1'b0;
            shift_r  <= 12'd0;
            simm_r   <= 24'd0;
            dest_r   <= 4'd0;
            src1_r   <= 4'd0;
            src2_r   <= 4'd0;
            sr_r     <= 4'd0;
            cnt_r    <= 16'd0;
        end else begin
            ctrl_r   <= ctrl_nxt_s;
            valid_r  <= valid_nxt_s;
            pc_r     <= pc_nxt_s;
            val_rn_r <= val_rn_nxt_s;
            val_rm_r <= val_rm_nxt_s;
            imm_r    <= imm_nxt_s;
            shift_r  <= shift_nxt_s;
            simm_r   <= simm_nxt_s;
            dest_r   <= dest_nxt_s;
            src1_r   <= src1_nxt_s;
            src2_r   <= src2_nxt_s;
            sr_r     <= sr_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign exe_cmd       = ctrl_r[8:5];
    assign mem_w_en      = ctrl_r[4];
    assign mem_r_en      = ctrl_r[3];
    assign wb_en         = ctrl_r[2];
    assign b             = ctrl_r[1];
    assign s             = ctrl_r[0];
    assign pc            = pc_r;
    assign val_rn        = val_rn_r;
    assign val_rm        = val_rm_r;
    assign imm           = imm_r;
    assign shift_operand = shift_r;
    assign signed_imm_24 = simm_r;
    assign dest          = dest_r;
    assign src1          = src1_r;
    assign src2          = src2_r;
    assign sr            = sr_r;
    assign valid_out     = valid_r;
    assign bubble_cnt    = cnt_r;

endmodule
